// File: rtl/collatz_host_pkg.sv
// collatz_host_pkg: shared widths, control-bit positions, read addresses and FSM states for the Collatz host driver
package collatz_host_pkg;
  localparam int BITS = 144;
  localparam int NBYTES = BITS / 8;
  localparam int WR_BIT = 7;
  localparam int GO_BIT = 6;
  localparam int SEL_PR_BIT = 5;
  localparam logic [7:0] ADDR_OLEN_L = 8'h00;
  localparam logic [7:0] ADDR_OLEN_H = 8'h01;
  localparam logic [7:0] ADDR_PR_L = 8'h20;
  localparam logic [7:0] ADDR_PR_H = 8'h21;
  typedef enum logic [2:0] {IDLE, LOAD, GO, GUARD, WAIT, READ, DONE} state_t;
  function automatic logic [7:0] read_addr(input logic [1:0] i);
    return i == 2'd0 ? ADDR_OLEN_L : i == 2'd1 ? ADDR_OLEN_H : i == 2'd2 ? ADDR_PR_L : ADDR_PR_H;
  endfunction
endpackage

// File: rtl/collatz_host_watchdog.sv
// collatz_host_watchdog: counts cycles while run is high and flags the cycle the count reaches LIMIT
// Ports: clk, rst_n (async active-low), run (count enable, clears when low), expired (high on the LIMIT-th run cycle)
module collatz_host_watchdog #(
  parameter int LIMIT = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= run ? cnt + 32'd1 : '0;
  assign expired = run && cnt == 32'(LIMIT - 1);
endmodule

// File: rtl/collatz_host_driver.sv
// collatz_host_driver: loads a seed into the Collatz core over its byte pins, starts it, waits for busy to drop and reads results
module collatz_host_driver
  import collatz_host_pkg::*;
#(
  parameter int BITS = collatz_host_pkg::BITS,
  parameter int NBYTES = BITS / 8,
  parameter int GUARD = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] seed,
  output logic            ready,
  output logic            done,
  output logic [15:0]     orbit_len,
  output logic [15:0]     path_record,
  output logic            timeout,
  output logic [7:0]      dev_data,
  output logic [7:0]      dev_ctrl,
  input  logic [7:0]      dev_rdata,
  input  logic            dev_busy
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, olen_n, pr_n;
  logic [BITS-1:0] sr, sr_n;
  logic ready_n, done_n, timeout_n, expired;
  logic [7:0] data_n, ctrl_n;
`ifdef COLLATZ_HOST_TIMEOUT_EN
  collatz_host_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .run(state == collatz_host_pkg::GUARD || state == WAIT),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    olen_n = orbit_len;
    pr_n = path_record;
    timeout_n = timeout;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        sr_n = seed;
        cnt_n = '0;
        timeout_n = 1'b0;
      end
      LOAD: begin
        sr_n = sr >> 8;
        cnt_n = cnt == 16'(NBYTES - 1) ? '0 : cnt + 16'd1;
        state_n = cnt == 16'(NBYTES - 1) ? GO : LOAD;
      end
      GO: begin
        state_n = collatz_host_pkg::GUARD;
        cnt_n = '0;
      end
      collatz_host_pkg::GUARD: begin
        cnt_n = cnt + 16'd1;
        state_n = cnt == 16'(GUARD - 1) ? WAIT : collatz_host_pkg::GUARD;
      end
      WAIT: if (!dev_busy) begin
        state_n = READ;
        cnt_n = '0;
      end
      READ: begin
        sr_n = cnt[0] ? {dev_rdata, sr[BITS-1:8]} : sr;
        cnt_n = cnt + 16'd1;
        if (cnt == 16'd7) begin
          state_n = DONE;
          olen_n = sr_n[BITS-17 -: 16];
          pr_n = sr_n[BITS-1 -: 16];
        end
      end
      default: state_n = IDLE;
    endcase
    if (expired) begin
      state_n = DONE;
      timeout_n = 1'b1;
      olen_n = '0;
      pr_n = '0;
    end
    ready_n = state_n == IDLE;
    done_n = state_n == DONE;
    data_n = state_n == LOAD ? sr_n[7:0] : 8'h00;
    ctrl_n = state_n == LOAD ? 8'(1 << WR_BIT) | {3'b000, cnt_n[4:0]}
           : state_n == GO ? 8'(1 << GO_BIT)
           : state_n == READ ? read_addr(cnt_n[2:1])
           : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ready <= 1'b1;
      done <= 1'b0;
      orbit_len <= '0;
      path_record <= '0;
      timeout <= 1'b0;
      dev_data <= '0;
      dev_ctrl <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      ready <= ready_n;
      done <= done_n;
      orbit_len <= olen_n;
      path_record <= pr_n;
      timeout <= timeout_n;
      dev_data <= data_n;
      dev_ctrl <= ctrl_n;
    end
endmodule

// File: tb/tb_collatz_host_driver.sv
// tb_collatz_host_driver: directed bench for collatz_host_driver against a behavioural Collatz device on its pins
module tb_collatz_host_driver;
  localparam int NB = 18;
  localparam int TO = 200;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [143:0] seed = '0;
  logic ready, done, timeout, dev_busy;
  logic [15:0] orbit_len, path_record;
  logic [7:0] dev_data, dev_ctrl, dev_rdata;
  int n_cmp = 0, n_bad = 0, n_conflict = 0, n_rd = 0, n_done = 0;
  logic [4:0] wr_addr[$];
  logic [7:0] wr_data[$];
  always #5 clk = ~clk;
  collatz_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .ready(ready), .done(done),
    .orbit_len(orbit_len), .path_record(path_record), .timeout(timeout),
    .dev_data(dev_data), .dev_ctrl(dev_ctrl), .dev_rdata(dev_rdata), .dev_busy(dev_busy)
  );
  logic [7:0] mem [0:31];
  logic [143:0] img;
  logic [15:0] d_olen, d_pr;
  int d_rem;
  logic d_busy, stub_busy = 1'b0;
  assign dev_busy = d_busy | stub_busy;
  always_comb begin
    img = '0;
    for (int i = 0; i < NB; i++) img[i*8 +: 8] = mem[i];
  end
  function automatic int steps_of(input logic [143:0] s);
    logic [145:0] x;
    int n;
    x = {2'b00, s};
    n = 0;
    do begin
      x = x[0] ? x * 146'd3 + 146'd1 : x >> 1;
      n++;
    end while (x != 146'd1 && n < 100000);
    return n;
  endfunction
  function automatic logic [15:0] top_of(input logic [143:0] s);
    logic [145:0] x, mx;
    int n;
    x = {2'b00, s};
    mx = x;
    n = 0;
    do begin
      x = x[0] ? x * 146'd3 + 146'd1 : x >> 1;
      if (x > mx) mx = x;
      n++;
    end while (x != 146'd1 && n < 100000);
    return mx[143:128];
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_busy <= 1'b0;
      d_rem <= 0;
      d_olen <= '0;
      d_pr <= '0;
      dev_rdata <= '0;
    end else begin
      if (dev_ctrl[7]) mem[dev_ctrl[4:0]] <= dev_data;
      if (dev_ctrl[6]) begin
        d_olen <= d_olen + 16'(steps_of(img));
        d_pr <= top_of(img);
        d_busy <= 1'b1;
        d_rem <= steps_of(img);
      end else if (d_busy) begin
        d_rem <= d_rem - 1;
        if (d_rem == 1) d_busy <= 1'b0;
      end
      dev_rdata <= dev_ctrl[5] ? (dev_ctrl[0] ? d_pr[15:8] : d_pr[7:0])
                               : (dev_ctrl[0] ? d_olen[15:8] : d_olen[7:0]);
    end
  always @(negedge clk) begin
    if (dev_ctrl[7]) begin
      wr_addr.push_back(dev_ctrl[4:0]);
      wr_data.push_back(dev_data);
    end
    if (dev_ctrl[7] && dev_ctrl[6]) n_conflict++;
    if (dev_ctrl == 8'h01 || dev_ctrl == 8'h20 || dev_ctrl == 8'h21) n_rd++;
    if (done) n_done++;
  end
  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic accept(input logic [143:0] s);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_ready got %b want 1", ready);
    end
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait got done=%b after %0d cycles want 1", done, lat);
    end
  endtask
  task automatic test_reset;
    do_reset;
    n_cmp += 7;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", ready); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    if (orbit_len !== 16'h0) begin n_bad++; $display("FAIL rst_olen got %h want 0000", orbit_len); end
    if (path_record !== 16'h0) begin n_bad++; $display("FAIL rst_pr got %h want 0000", path_record); end
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout got %b want 0", timeout); end
    if (dev_data !== 8'h0) begin n_bad++; $display("FAIL rst_data got %h want 00", dev_data); end
    if (dev_ctrl !== 8'h0) begin n_bad++; $display("FAIL rst_ctrl got %h want 00", dev_ctrl); end
  endtask
  task automatic test_seed27;
    int lat;
    do_reset;
    wr_addr.delete();
    wr_data.delete();
    n_conflict = 0;
    accept(144'd27);
    wait_done(lat);
    n_cmp += 5;
    if (orbit_len !== 16'h006F) begin n_bad++; $display("FAIL s27_olen got %h want 006f", orbit_len); end
    if (path_record !== 16'h0000) begin n_bad++; $display("FAIL s27_pr got %h want 0000", path_record); end
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL s27_timeout got %b want 0", timeout); end
    if (wr_addr.size() != NB) begin n_bad++; $display("FAIL s27_nwrites got %0d want %0d", wr_addr.size(), NB); end
    if (n_conflict != 0) begin n_bad++; $display("FAIL s27_wr_go_overlap got %0d want 0", n_conflict); end
    for (int i = 0; i < NB && i < wr_addr.size(); i++) begin
      n_cmp += 2;
      if (wr_addr[i] !== 5'(i)) begin n_bad++; $display("FAIL s27_addr%0d got %0d want %0d", i, wr_addr[i], i); end
      if (wr_data[i] !== (i == 0 ? 8'h1B : 8'h00)) begin
        n_bad++;
        $display("FAIL s27_byte%0d got %h want %h", i, wr_data[i], i == 0 ? 8'h1B : 8'h00);
      end
    end
    @(posedge clk);
    #1;
    n_cmp += 3;
    if (done !== 1'b0) begin n_bad++; $display("FAIL s27_done_pulse got %b want 0", done); end
    if (ready !== 1'b1) begin n_bad++; $display("FAIL s27_ready_after got %b want 1", ready); end
    if (orbit_len !== 16'h006F) begin n_bad++; $display("FAIL s27_olen_hold got %h want 006f", orbit_len); end
  endtask
  task automatic test_pow2;
    int lat;
    logic [143:0] s;
    s = '0;
    s[143] = 1'b1;
    do_reset;
    accept(s);
    wait_done(lat);
    n_cmp += 2;
    if (orbit_len !== 16'h008F) begin n_bad++; $display("FAIL pow2_olen got %h want 008f", orbit_len); end
    if (path_record !== 16'h8000) begin n_bad++; $display("FAIL pow2_pr got %h want 8000", path_record); end
  endtask
  task automatic test_seed2;
    int lat;
    do_reset;
    accept(144'd2);
    wait_done(lat);
    n_cmp += 3;
    if (orbit_len !== 16'h0001) begin n_bad++; $display("FAIL s2_olen got %h want 0001", orbit_len); end
    if (path_record !== 16'h0000) begin n_bad++; $display("FAIL s2_pr got %h want 0000", path_record); end
    if (lat != 31) begin n_bad++; $display("FAIL s2_latency got %0d want 31", lat); end
  endtask
  task automatic test_ignore_start;
    int lat, d0;
    do_reset;
    d0 = n_done;
    accept(144'd27);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL ign_ready_busy got %b want 0", ready); end
    seed = 144'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (60) @(negedge clk);
    n_cmp += 2;
    if (n_done - d0 != 1) begin n_bad++; $display("FAIL ign_done_count got %0d want 1", n_done - d0); end
    if (orbit_len !== 16'h006F) begin n_bad++; $display("FAIL ign_olen got %h want 006f", orbit_len); end
  endtask
  task automatic test_reset_mid_load;
    int lat, w;
    do_reset;
    accept(144'd2);
    wait_done(lat);
    accept(144'd27);
    w = 0;
    while (dev_ctrl !== 8'h89 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (dev_ctrl !== 8'h89) begin n_bad++; $display("FAIL mid_reach_byte9 got %h want 89", dev_ctrl); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 7;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", ready); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", done); end
    if (orbit_len !== 16'h0) begin n_bad++; $display("FAIL mid_olen got %h want 0000", orbit_len); end
    if (path_record !== 16'h0) begin n_bad++; $display("FAIL mid_pr got %h want 0000", path_record); end
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL mid_timeout got %b want 0", timeout); end
    if (dev_data !== 8'h0) begin n_bad++; $display("FAIL mid_data got %h want 00", dev_data); end
    if (dev_ctrl !== 8'h0) begin n_bad++; $display("FAIL mid_ctrl got %h want 00", dev_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
    accept(144'd1);
    wait_done(lat);
    n_cmp++;
    if (orbit_len !== 16'h0003) begin n_bad++; $display("FAIL mid_seed1_olen got %h want 0003", orbit_len); end
  endtask
  task automatic test_timeout;
    int lat;
`ifdef COLLATZ_HOST_TIMEOUT_EN
    int r0;
    do_reset;
    stub_busy = 1'b1;
    r0 = n_rd;
    accept(144'd27);
    wait_done(lat);
    stub_busy = 1'b0;
    n_cmp += 5;
    if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got %b want 1", timeout); end
    if (orbit_len !== 16'h0) begin n_bad++; $display("FAIL to_olen got %h want 0000", orbit_len); end
    if (path_record !== 16'h0) begin n_bad++; $display("FAIL to_pr got %h want 0000", path_record); end
    if (n_rd != r0) begin n_bad++; $display("FAIL to_reads got %0d want 0", n_rd - r0); end
    if (lat != NB + 2 + TO) begin n_bad++; $display("FAIL to_latency got %0d want %0d", lat, NB + 2 + TO); end
`else
    do_reset;
    accept(144'd27);
    wait_done(lat);
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_off got %b want 0", timeout); end
`endif
  endtask
  initial begin
    test_reset;
    test_seed27;
    test_pow2;
    test_seed2;
    test_ignore_start;
    test_reset_mid_load;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
